// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Summary  : Registered instruction-decode stage between fetch and execute.
//            Splits 9-bit instructions into ALU / data-class fields, inserts
//            load-use bubbles, flags HALT and reserved encodings, and counts
//            dispatched instructions. Valid/ready handshake on both sides.
// Revision : 1.0 - initial release
// ============================================================================
// ALU opcode map (bit8 = 0, opcode in [7:5]):
//   000 kADD  001 kLSL  010 kLSR  011 kXOR  100 kAND  101 kOR  110 kSET  111 kSUB
// kSET carries a 5-bit immediate in [4:0] instead of a register field.
// HALT is dispatched as a data-class op with data_op = 01 (the otherwise
// unused data opcode slot), so execute can recognise it.
module decode_stage #(
  parameter int BUBBLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       in_instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_alu,
  output logic [2:0]       alu_op,
  output logic [1:0]       data_op,
  output logic             is_flag,
  output logic [2:0]       reg_a,
  output logic [2:0]       reg_b,
  output logic [4:0]       imm5,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] dispatch_cnt
);

  // FSM state encoding
  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_FULL   = 2'd1;
  localparam logic [1:0] c_ST_BUBBLE = 2'd2;
  localparam logic [1:0] c_ST_HALT   = 2'd3;

  // ALU opcodes referenced by the decoder
  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SET = 3'b110;

  // Data-class opcodes
  localparam logic [1:0] c_DOP_MOVE  = 2'b00;
  localparam logic [1:0] c_DOP_HALT  = 2'b01;
  localparam logic [1:0] c_DOP_STORE = 2'b10;
  localparam logic [1:0] c_DOP_LOAD  = 2'b11;

  // Bubble configuration; a zero setting disables load-use stalls entirely
  localparam logic       c_HAS_BUBBLE = (BUBBLE_CYCLES > 0);
  localparam logic [1:0] c_BUB_INIT   = 2'(BUBBLE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // FSM and bubble counter
  logic [1:0] r_state;
  logic [1:0] w_nextState;
  logic [1:0] r_bubbleCnt;

  // Registered decoded fields for the instruction held in FULL
  logic       r_isAlu;
  logic [2:0] r_aluOp;
  logic [1:0] r_dataOp;
  logic       r_isFlag;
  logic [2:0] r_regA;
  logic [2:0] r_regB;
  logic [4:0] r_imm5;
  logic       r_isLoad;
  logic       r_isHalt;

  // Sticky status and dispatch counter
  logic             r_illegal;
  logic [CNT_W-1:0] r_dispatchCnt;

  // Combinational decode of the incoming instruction
  logic       w_decIsAlu;
  logic [2:0] w_decAluOp;
  logic [1:0] w_decDataOp;
  logic       w_decIsFlag;
  logic [2:0] w_decRegA;
  logic [2:0] w_decRegB;
  logic [4:0] w_decImm5;
  logic       w_decIsLoad;
  logic       w_decIsHalt;
  logic       w_decIllegal;

  // Handshake events
  logic w_accept;
  logic w_dispatch;

  // Field extraction from the raw 9-bit instruction; reserved codes become kADD r0
  always_comb begin
    w_decIsAlu   = 1'b0;
    w_decAluOp   = 3'b000;
    w_decDataOp  = 2'b00;
    w_decIsFlag  = 1'b0;
    w_decRegA    = 3'b000;
    w_decRegB    = 3'b000;
    w_decImm5    = 5'b00000;
    w_decIsLoad  = 1'b0;
    w_decIsHalt  = 1'b0;
    w_decIllegal = 1'b0;
    if (!in_instr[8]) begin
      w_decIsAlu = 1'b1;
      w_decAluOp = in_instr[7:5];
      if (in_instr[7:5] == c_OP_SET) begin
        w_decImm5 = in_instr[4:0];
      end else begin
        w_decRegA = in_instr[4:2];
      end
    end else begin
      case (in_instr[7:6])
        2'b00: begin
          w_decDataOp = c_DOP_MOVE;
          w_decIsFlag = in_instr[5];
          w_decRegA   = in_instr[4:2];
        end
        2'b10: begin
          w_decDataOp = c_DOP_STORE;
          w_decRegA   = in_instr[5:3];
          w_decRegB   = in_instr[2:0];
        end
        2'b11: begin
          w_decDataOp = c_DOP_LOAD;
          w_decRegA   = in_instr[5:3];
          w_decRegB   = in_instr[2:0];
          w_decIsLoad = 1'b1;
        end
        default: begin
          if (&in_instr[5:0]) begin
            w_decDataOp = c_DOP_HALT;
            w_decIsHalt = 1'b1;
          end else begin
            w_decIsAlu   = 1'b1;
            w_decAluOp   = c_OP_ADD;
            w_decIllegal = 1'b1;
          end
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_ST_RUN: begin
        if (in_valid) begin
          w_nextState = c_ST_FULL;
        end
      end
      c_ST_FULL: begin
        if (out_ready) begin
          if (r_isLoad && c_HAS_BUBBLE) begin
            w_nextState = c_ST_BUBBLE;
          end else if (r_isHalt) begin
            w_nextState = c_ST_HALT;
          end else if (in_valid) begin
            w_nextState = c_ST_FULL;
          end else begin
            w_nextState = c_ST_RUN;
          end
        end
      end
      c_ST_BUBBLE: begin
        if (r_bubbleCnt <= 2'd1) begin
          w_nextState = c_ST_RUN;
        end
      end
      default: begin
        w_nextState = c_ST_HALT;
      end
    endcase
  end

  // Handshake outputs per state; FULL only passes through when the held op cannot stall
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (r_state)
      c_ST_RUN: begin
        in_ready = 1'b1;
      end
      c_ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~(r_isLoad & c_HAS_BUBBLE) & ~r_isHalt;
      end
      c_ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign w_accept   = in_valid & in_ready;
  assign w_dispatch = out_valid & out_ready;

  // Load-use bubble countdown, armed when a LOAD leaves the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubbleCnt <= 2'd0;
    end else if (w_dispatch && r_isLoad && c_HAS_BUBBLE) begin
      r_bubbleCnt <= c_BUB_INIT;
    end else if (r_state == c_ST_BUBBLE && r_bubbleCnt != 2'd0) begin
      r_bubbleCnt <= r_bubbleCnt - 2'd1;
    end
  end

  // Decoded-field holding register, loaded on every accepted instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isAlu  <= 1'b0;
      r_aluOp  <= 3'b000;
      r_dataOp <= 2'b00;
      r_isFlag <= 1'b0;
      r_regA   <= 3'b000;
      r_regB   <= 3'b000;
      r_imm5   <= 5'b00000;
      r_isLoad <= 1'b0;
      r_isHalt <= 1'b0;
    end else if (w_accept) begin
      r_isAlu  <= w_decIsAlu;
      r_aluOp  <= w_decAluOp;
      r_dataOp <= w_decDataOp;
      r_isFlag <= w_decIsFlag;
      r_regA   <= w_decRegA;
      r_regB   <= w_decRegB;
      r_imm5   <= w_decImm5;
      r_isLoad <= w_decIsLoad;
      r_isHalt <= w_decIsHalt;
    end
  end

  // Sticky illegal flag, raised when a reserved encoding is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_accept && w_decIllegal) begin
      r_illegal <= 1'b1;
    end
  end

  // Dispatch counter; wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dispatchCnt <= '0;
    end else if (w_dispatch) begin
      r_dispatchCnt <= r_dispatchCnt + c_CNT_ONE;
    end
  end

  assign is_alu       = r_isAlu;
  assign alu_op       = r_aluOp;
  assign data_op      = r_dataOp;
  assign is_flag      = r_isFlag;
  assign reg_a        = r_regA;
  assign reg_b        = r_regB;
  assign imm5         = r_imm5;
  assign illegal      = r_illegal;
  assign dispatch_cnt = r_dispatchCnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Summary  : Self-checking bench for decode_stage: transaction-level model
//            with an expected-dispatch queue plus literal directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  localparam int BUB = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        keep2 = 1'b0;
  logic        rst_n2;
  logic [8:0]  in_instr = 9'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, is_alu, is_flag, halted, illegal;
  logic [2:0]  alu_op, reg_a, reg_b;
  logic [1:0]  data_op;
  logic [4:0]  imm5;
  logic [15:0] dispatch_cnt;

  logic        in_ready2, out_valid2, is_alu2, is_flag2, halted2, illegal2;
  logic [2:0]  alu_op2, reg_a2, reg_b2;
  logic [1:0]  data_op2;
  logic [4:0]  imm52;
  logic [15:0] dispatch_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Second instance shares stimulus but can be kept out of a reset pulse
  assign rst_n2 = rst_n | keep2;

  decode_stage #(.BUBBLE_CYCLES(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .is_alu(is_alu), .alu_op(alu_op), .data_op(data_op), .is_flag(is_flag),
    .reg_a(reg_a), .reg_b(reg_b), .imm5(imm5), .halted(halted),
    .illegal(illegal), .dispatch_cnt(dispatch_cnt)
  );

  decode_stage #(.BUBBLE_CYCLES(BUB), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n2), .in_instr(in_instr), .in_valid(in_valid),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
    .is_alu(is_alu2), .alu_op(alu_op2), .data_op(data_op2), .is_flag(is_flag2),
    .reg_a(reg_a2), .reg_b(reg_b2), .imm5(imm52), .halted(halted2),
    .illegal(illegal2), .dispatch_cnt(dispatch_cnt2)
  );

  typedef struct packed {
    logic       isAlu;
    logic [2:0] aluOp;
    logic [1:0] dataOp;
    logic       isFlag;
    logic [2:0] regA;
    logic [2:0] regB;
    logic [4:0] imm5;
    logic       isLoad;
    logic       isHalt;
    logic       bad;
  } exp_t;

  exp_t        q[$];
  int          mBub = 0;
  logic        mHalted = 1'b0;
  logic        mIllegal = 1'b0;
  logic [15:0] mCnt = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected fields from the instruction-set rules
  function automatic exp_t decode(input logic [8:0] i);
    exp_t e;
    e = '0;
    if (i[8] == 1'b0) begin
      e.isAlu = 1'b1;
      e.aluOp = i[7:5];
      if (i[7:5] == 3'b110) e.imm5 = i[4:0];
      else                  e.regA = i[4:2];
    end else if (i[7:6] == 2'b00) begin
      e.isFlag = i[5];
      e.regA   = i[4:2];
    end else if (i[7:6] == 2'b10 || i[7:6] == 2'b11) begin
      e.dataOp = i[7:6];
      e.regA   = i[5:3];
      e.regB   = i[2:0];
      e.isLoad = (i[7:6] == 2'b11);
    end else if (i[5:0] == 6'd63) begin
      e.dataOp = 2'b01;
      e.isHalt = 1'b1;
    end else begin
      e.isAlu = 1'b1;
      e.bad   = 1'b1;
    end
    return e;
  endfunction

  // Compare process: check every cycle at negedge, advance the model at posedge
  initial begin
    logic       acc, disp, expRdy;
    logic [8:0] ins;
    exp_t       h, e;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      disp = 1'b0;
      ins = in_instr;
      if (!rst_n) begin
        q.delete();
        mBub = 0;
        mHalted = 1'b0;
        mIllegal = 1'b0;
        mCnt = 16'd0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cnt", dispatch_cnt, 0);
        chk("rst_flags", {halted, illegal, is_alu, alu_op, data_op, is_flag, reg_a, reg_b, imm5}, 0);
      end else begin
        if (mHalted || mBub > 0)  expRdy = 1'b0;
        else if (q.size() == 0)   expRdy = 1'b1;
        else expRdy = out_ready && !(q[0].isLoad && BUB > 0) && !q[0].isHalt;
        chk("in_ready", in_ready, expRdy);
        chk("out_valid", out_valid, q.size() > 0);
        chk("halted", halted, mHalted);
        chk("illegal", illegal, mIllegal);
        chk("dispatch_cnt", dispatch_cnt, mCnt);
        if (q.size() > 0) begin
          chk("is_alu", is_alu, q[0].isAlu);
          chk("alu_op", alu_op, q[0].aluOp);
          chk("data_op", data_op, q[0].dataOp);
          chk("is_flag", is_flag, q[0].isFlag);
          chk("reg_a", reg_a, q[0].regA);
          chk("reg_b", reg_b, q[0].regB);
          chk("imm5", imm5, q[0].imm5);
        end
        acc  = in_valid && expRdy;
        disp = (q.size() > 0) && out_ready;
      end
      @(posedge clk);
      if (rst_n) begin
        if (mBub > 0) mBub--;
        if (disp) begin
          h = q.pop_front();
          mCnt++;
          if (h.isHalt) mHalted = 1'b1;
          if (h.isLoad && BUB > 0) mBub = BUB;
        end
        if (acc) begin
          e = decode(ins);
          q.push_back(e);
          if (e.bad) mIllegal = 1'b1;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Present one instruction and hold it until the stage takes it (bounded)
  task automatic send(input logic [8:0] ins);
    int n;
    n = 0;
    in_instr = ins;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_handshake", in_ready, 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_in_ready", in_ready, 1);
    chk("lit_rst_out_valid", out_valid, 0);
    chk("lit_rst_cnt", dispatch_cnt, 0);
    repeat (2) sync();
    rst_n = 1'b1;
    sync();

    // LSL r2
    send(9'b0_001_010_00);
    @(negedge clk);
    chk("lit_lsl_valid", out_valid, 1);
    chk("lit_lsl_fields", {is_alu, alu_op, reg_a}, {1'b1, 3'b001, 3'd2});
    sync();
    chk("lit_lsl_cnt", dispatch_cnt, 1);

    // Back-to-back ALU ops, then kSET with immediate 21
    send(9'b0_000_001_00);
    send(9'b0_011_010_00);
    send(9'b0_111_011_00);
    @(negedge clk);
    chk("lit_sub_op", alu_op, 3'b111);
    chk("lit_b2b_ready", in_ready, 1);
    sync();
    send(9'b0_110_10101);
    @(negedge clk);
    chk("lit_set_imm", {imm5, reg_a}, {5'd21, 3'd0});
    sync();
    repeat (2) sync();

    // LOAD r3,r5 followed by ADD: one bubble cycle
    send(9'b1_11_011_101);
    @(negedge clk);
    chk("lit_load_fields", {data_op, reg_a, reg_b}, {2'b11, 3'd3, 3'd5});
    sync();
    chk("lit_bubble", {in_ready, out_valid}, 2'b00);
    send(9'b0_000_100_00);
    repeat (2) sync();

    // FLAG r6 held for three cycles with out_ready low
    out_ready = 1'b0;
    send(9'b1_00_1_110_00);
    repeat (3) begin
      @(negedge clk);
      chk("lit_flag_stall", {out_valid, in_ready, is_flag, data_op, reg_a}, {1'b1, 1'b0, 1'b1, 2'b00, 3'd6});
    end
    sync();
    out_ready = 1'b1;
    sync();
    chk("lit_flag_done", {out_valid, dispatch_cnt}, {1'b0, 16'd8});

    // STORE and MOVE
    send(9'b1_10_101_010);
    send(9'b1_00_0_011_00);
    repeat (2) sync();

    // Reserved encoding then HALT, then keep offering instructions
    send(9'b1_01_000000);
    @(negedge clk);
    chk("lit_illegal_fields", {is_alu, alu_op, reg_a, illegal}, {1'b1, 3'b000, 3'd0, 1'b1});
    sync();
    send(9'b1_01_111111);
    sync();
    chk("lit_halted", {halted, in_ready, dispatch_cnt}, {1'b1, 1'b0, 16'd12});
    in_instr = 9'b0_000_001_00;
    in_valid = 1'b1;
    repeat (5) sync();
    in_valid = 1'b0;
    chk("lit_halt_sticky", {halted, dispatch_cnt}, {1'b1, 16'd12});

    // Fresh reset, then run the counter up to all-ones ending in a LOAD
    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    sync();
    for (int k = 0; k < 65534; k++) send(9'b0_000_001_00);
    send(9'b1_11_001_010);
    sync();
    chk("lit_cnt_ffff", dispatch_cnt, 16'hFFFF);
    chk("lit_cnt2_ffff", dispatch_cnt2, 16'hFFFF);
    chk("lit_in_bubble", {in_ready, out_valid}, 2'b00);

    // Asynchronous reset mid-bubble on the first instance only
    keep2 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("lit_async_cnt", dispatch_cnt, 0);
    chk("lit_async_hs", {in_ready, out_valid}, 2'b10);
    chk("lit_async_fields", {is_alu, data_op, reg_a, reg_b, illegal, halted}, 0);
    chk("lit_cnt2_hold", dispatch_cnt2, 16'hFFFF);
    sync();
    rst_n = 1'b1;
    keep2 = 1'b0;

    // 65536th dispatch on the second instance wraps its counter
    send(9'b0_000_001_00);
    sync();
    chk("lit_cnt2_wrap", dispatch_cnt2, 16'd0);
    chk("lit_cnt_after_rst", dispatch_cnt, 16'd1);
    repeat (2) sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
